// File: rtl/robin_mem_pkg.sv
// Shared types and constants for the cpu memory responder.
// Holds the read-state encoding, the default address width and the halt-dump window.
package robin_mem_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 9;
    localparam int DUMP_BASE          = 2;
    localparam int DUMP_LEN           = 4;

    typedef enum logic [1:0] {
        RELOAD,
        WAIT,
        READY
    } rd_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Bundle of the cpu read/write ports and the host preload/dump port.
// The master modport is the cpu/host side; the slave modport is the responder.
interface mem_responder_if
    import robin_mem_pkg::*;
#(
    parameter int addr_width = ADDR_WIDTH_DEFAULT
);
    logic [addr_width-1:0] mem_raddr;
    logic [7:0]            mem_data_out;
    logic                  mem_ready;
    logic [addr_width-1:0] mem_waddr;
    logic [7:0]            mem_data_in;
    logic                  mem_write;
    logic [addr_width-1:0] host_addr;
    logic [7:0]            host_wdata;
    logic                  host_we;
    logic                  host_re;
    logic [7:0]            host_rdata;
    logic                  host_rvalid;
    logic                  host_busy;

    modport master (
        output mem_raddr, mem_waddr, mem_data_in, mem_write,
        output host_addr, host_wdata, host_we, host_re,
        input  mem_data_out, mem_ready, host_rdata, host_rvalid, host_busy
    );

    modport slave (
        input  mem_raddr, mem_waddr, mem_data_in, mem_write,
        input  host_addr, host_wdata, host_we, host_re,
        output mem_data_out, mem_ready, host_rdata, host_rvalid, host_busy
    );
endinterface

// File: rtl/ram_byte_2p.sv
// Byte-wide RAM: one synchronous write port, two asynchronous read taps, no reset.
// Write lands on the clock edge; reads are combinational, no backpressure.
module ram_byte_2p #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [addr_width-1:0] raddr_a,
    output logic [7:0]            rdata_a,
    input  logic [addr_width-1:0] raddr_b,
    output logic [7:0]            rdata_b
);
    logic [7:0] mem [0:(2**addr_width)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/mem_responder.sv
// cpu memory responder with programmable read wait states and a low-priority host port.
// Read data ready 1+wait_states edges after address capture; host is stalled via host_busy on cpu writes.
module mem_responder
    import robin_mem_pkg::*;
#(
    parameter int addr_width  = ADDR_WIDTH_DEFAULT,
    parameter int wait_states = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam logic [3:0] WS = 4'(wait_states);

    rd_state_t             state_q, state_d;
    logic [addr_width-1:0] raddr_q, raddr_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [7:0]            data_q, data_d;
    logic [7:0]            host_rdata_q;
    logic                  host_rvalid_q;

    logic                  host_req, host_go, ram_we;
    logic [addr_width-1:0] ram_waddr;
    logic [7:0]            ram_wdata, ram_cpu_rdata, ram_host_rdata;
    logic                  cpu_hit, host_hit, addr_moved;

    // cpu write always wins the single RAM write port; the host retries.
    assign host_req      = bus.host_we | bus.host_re;
    assign bus.host_busy = host_req & bus.mem_write;
    assign host_go       = host_req & ~bus.mem_write;
    assign ram_we        = bus.mem_write | (host_go & bus.host_we);
    assign ram_waddr     = bus.mem_write ? bus.mem_waddr   : bus.host_addr;
    assign ram_wdata     = bus.mem_write ? bus.mem_data_in : bus.host_wdata;

    assign cpu_hit    = bus.mem_write && (bus.mem_waddr == raddr_q);
    assign host_hit   = host_go && bus.host_we && (bus.host_addr == raddr_q);
    assign addr_moved = bus.mem_raddr != raddr_q;

    ram_byte_2p #(.addr_width(addr_width)) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (raddr_q),
        .rdata_a (ram_cpu_rdata),
        .raddr_b (bus.host_addr),
        .rdata_b (ram_host_rdata)
    );

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        data_d  = data_q;
        unique case (state_q)
            RELOAD: begin
                raddr_d = bus.mem_raddr;
                cnt_d   = WS;
                ready_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (addr_moved) begin
                    raddr_d = bus.mem_raddr;
                    cnt_d   = WS;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d  = cpu_hit ? bus.mem_data_in : ram_cpu_rdata;
                    ready_d = 1'b1;
                    state_d = READY;
                end
            end
            READY: begin
                if (addr_moved) begin
                    raddr_d = bus.mem_raddr;
                    cnt_d   = WS;
                    ready_d = 1'b0;
                    state_d = WAIT;
                end else if (cpu_hit) begin
                    data_d = bus.mem_data_in;
                end else if (host_hit) begin
                    data_d = bus.host_wdata;
                end
            end
            default: state_d = RELOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RELOAD;
            raddr_q       <= '0;
            cnt_q         <= 4'd0;
            ready_q       <= 1'b0;
            data_q        <= 8'd0;
            host_rdata_q  <= 8'd0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            raddr_q       <= raddr_d;
            cnt_q         <= cnt_d;
            ready_q       <= ready_d;
            data_q        <= data_d;
            host_rvalid_q <= host_go & bus.host_re;
            if (host_go && bus.host_re) begin
                host_rdata_q <= ram_host_rdata;
            end
        end
    end

    assign bus.mem_ready    = ready_q;
    assign bus.mem_data_out = data_q;
    assign bus.host_rdata   = host_rdata_q;
    assign bus.host_rvalid  = host_rvalid_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (0 and 1 wait states) driven in lockstep.
// Checks directed scenarios plus random traffic against an age-based reference model.
module tb_mem_responder;
    import robin_mem_pkg::*;

    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] raddr = '0, c_waddr = '0, h_addr = '0;
    logic [7:0]    c_wdata = '0, h_wdata = '0;
    logic          c_we = 1'b0, h_we = 1'b0, h_re = 1'b0;

    mem_responder_if #(.addr_width(AW)) bus0 ();
    mem_responder_if #(.addr_width(AW)) bus1 ();

    assign bus0.mem_raddr   = raddr;
    assign bus0.mem_waddr   = c_waddr;
    assign bus0.mem_data_in = c_wdata;
    assign bus0.mem_write   = c_we;
    assign bus0.host_addr   = h_addr;
    assign bus0.host_wdata  = h_wdata;
    assign bus0.host_we     = h_we;
    assign bus0.host_re     = h_re;
    assign bus1.mem_raddr   = raddr;
    assign bus1.mem_waddr   = c_waddr;
    assign bus1.mem_data_in = c_wdata;
    assign bus1.mem_write   = c_we;
    assign bus1.host_addr   = h_addr;
    assign bus1.host_wdata  = h_wdata;
    assign bus1.host_we     = h_we;
    assign bus1.host_re     = h_re;

    mem_responder #(.addr_width(AW), .wait_states(0)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
    mem_responder #(.addr_width(AW), .wait_states(1)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: memory array plus, per instance, edges elapsed since address capture.
    logic [7:0]    mdl_mem [0:(2**AW)-1];
    int            ws_of  [2] = '{0, 1};
    bit            m_cap  [2];
    logic [AW-1:0] m_addr [2];
    int            m_age  [2];
    logic          m_rdy  [2];
    logic [7:0]    m_dat  [2];
    logic          m_hrv;
    logic [7:0]    m_hrd;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cap[k] = 1'b0;
            m_age[k] = 0;
            m_rdy[k] = 1'b0;
            m_dat[k] = 8'h00;
        end
        m_hrv = 1'b0;
        m_hrd = 8'h00;
    endtask

    task automatic model_edge();
        bit acc;
        acc = (h_we || h_re) && !c_we;
        for (int k = 0; k < 2; k++) begin
            if (!m_cap[k] || raddr != m_addr[k]) begin
                m_cap[k]  = 1'b1;
                m_addr[k] = raddr;
                m_age[k]  = 0;
                m_rdy[k]  = 1'b0;
            end else if (m_rdy[k]) begin
                if (c_we && c_waddr == m_addr[k]) m_dat[k] = c_wdata;
                else if (acc && h_we && h_addr == m_addr[k]) m_dat[k] = h_wdata;
            end else begin
                m_age[k]++;
                if (m_age[k] == ws_of[k] + 1) begin
                    m_rdy[k] = 1'b1;
                    m_dat[k] = (c_we && c_waddr == m_addr[k]) ? c_wdata : mdl_mem[m_addr[k]];
                end
            end
        end
        m_hrv = acc && h_re;
        if (m_hrv) m_hrd = mdl_mem[h_addr];
        if (c_we) mdl_mem[c_waddr] = c_wdata;
        else if (acc && h_we) mdl_mem[h_addr] = h_wdata;
    endtask

    // Inputs are set at the falling edge; one call covers one rising edge.
    task automatic tick();
        logic exp_busy;
        #1;
        exp_busy = (h_we | h_re) & c_we;
        chk("busy0", bus0.host_busy, exp_busy);
        chk("busy1", bus1.host_busy, exp_busy);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("ready0", bus0.mem_ready, m_rdy[0]);
        chk("data0",  bus0.mem_data_out, m_dat[0]);
        chk("ready1", bus1.mem_ready, m_rdy[1]);
        chk("data1",  bus1.mem_data_out, m_dat[1]);
        chk("hrvalid0", bus0.host_rvalid, m_hrv);
        chk("hrdata0",  bus0.host_rdata, m_hrd);
        chk("hrvalid1", bus1.host_rvalid, m_hrv);
        chk("hrdata1",  bus1.host_rdata, m_hrd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready0", bus0.mem_ready, 0);
        chk("rst_ready1", bus1.mem_ready, 0);
        chk("rst_data1", bus1.mem_data_out, 0);
        chk("rst_hrvalid", bus1.host_rvalid, 0);
        chk("rst_hrdata", bus1.host_rdata, 0);
        chk("rst_busy", bus1.host_busy, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle();
        c_we = 1'b0;
        h_we = 1'b0;
        h_re = 1'b0;
    endtask

    logic [7:0] dump_val [DUMP_LEN] = '{8'h00, 8'h00, 8'h01, 8'h2C};

    initial begin
        for (int a = 0; a < 2**AW; a++) mdl_mem[a] = 8'h00;
        model_reset();
        #2;
        do_reset();

        // Preload every byte via the host; moving raddr keeps both read ports unready.
        for (int a = 0; a < 2**AW; a++) begin
            raddr   = AW'(a);
            h_we    = 1'b1;
            h_addr  = AW'(a);
            h_wdata = (a == 0) ? 8'h12 : (a == 1) ? 8'h34 : (a == 4) ? 8'h44 :
                      (a == 9) ? 8'h11 : 8'($urandom_range(0, 255));
            tick();
        end
        idle();

        raddr = 9'd0;
        tick();
        tick();
        chk("ws1_n1_notready", bus1.mem_ready, 0);
        tick();
        chk("ws1_ready", bus1.mem_ready, 1);
        chk("ws1_data12", bus1.mem_data_out, 8'h12);
        raddr = 9'd1;
        tick();
        chk("ws1_drop", bus1.mem_ready, 0);
        tick();
        tick();
        chk("ws1_data34", bus1.mem_data_out, 8'h34);

        for (int i = 0; i < 4; i++) begin
            raddr = AW'(i % 2);
            tick();
            chk("ws0_toggle", bus0.mem_ready, 0);
        end
        tick();
        chk("ws0_hold_ready", bus0.mem_ready, 1);
        chk("ws0_hold_data", bus0.mem_data_out, 8'h34);

        raddr = 9'd3;
        repeat (3) tick();
        c_we = 1'b1; c_waddr = 9'd3; c_wdata = 8'hAB;
        tick();
        chk("coherent_ready", bus1.mem_ready, 1);
        chk("coherent_data", bus1.mem_data_out, 8'hAB);
        idle();
        raddr = 9'd5;
        c_wdata = 8'h00;
        tick();
        tick();
        c_we = 1'b1; c_waddr = 9'd5; c_wdata = 8'hAB;
        tick();
        chk("fwd_ready", bus1.mem_ready, 1);
        chk("fwd_data", bus1.mem_data_out, 8'hAB);
        idle();

        h_we = 1'b1; h_addr = 9'd4; h_wdata = 8'h55;
        c_we = 1'b1; c_waddr = 9'd7; c_wdata = 8'h66;
        #1;
        chk("host_busy_conflict", bus1.host_busy, 1);
        tick();
        c_we = 1'b0;
        tick();
        h_we = 1'b0; h_re = 1'b1;
        tick();
        chk("host_rd_valid", bus1.host_rvalid, 1);
        chk("host_rd_55", bus1.host_rdata, 8'h55);
        idle();
        tick();

        h_we = 1'b1; h_re = 1'b1; h_addr = 9'd9; h_wdata = 8'h22;
        tick();
        chk("we_re_old", bus1.host_rdata, 8'h11);
        h_we = 1'b0;
        tick();
        chk("we_re_new", bus1.host_rdata, 8'h22);
        idle();

        for (int i = 0; i < DUMP_LEN; i++) begin
            c_we = 1'b1; c_waddr = AW'(DUMP_BASE + i); c_wdata = dump_val[i];
            tick();
        end
        idle();
        raddr = 9'd2;
        tick();
        tick();
        chk("pre_rst_ready0", bus0.mem_ready, 1);
        #2;
        do_reset();
        for (int i = 0; i < DUMP_LEN; i++) begin
            h_re = 1'b1; h_addr = AW'(DUMP_BASE + i);
            tick();
            chk("dump", bus1.host_rdata, dump_val[i]);
        end
        idle();

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) raddr = AW'($urandom_range(0, 7));
            c_we    = ($urandom_range(0, 3) == 0);
            c_waddr = AW'($urandom_range(0, 7));
            c_wdata = 8'($urandom_range(0, 255));
            h_we    = ($urandom_range(0, 3) == 0);
            h_re    = ($urandom_range(0, 3) == 0);
            h_addr  = AW'($urandom_range(0, 7));
            h_wdata = 8'($urandom_range(0, 255));
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the cpu memory interface: byte-wide, `2**addr_width`-deep RAM with a read port (`mem_raddr` → `mem_data_out`/`mem_ready`) and a write port (`mem_waddr`/`mem_data_in`/`mem_write`).
- Inserts a programmable number of read wait states and signals completion on `mem_ready`.
- Also exposes a low-priority host port used to preload programs and read back the halt dump (bytes 2..5) after the cpu raises `halted`.

Parameters:
- `addr_width`, 9, width of all addresses; depth = `2**addr_width`.
- `wait_states`, 1, extra cycles between read-address capture and `mem_ready`; legal 0..15.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_raddr`  in  `addr_width`  cpu read address.
- `mem_data_out`  out  8  read data to cpu.
- `mem_ready`  out  1  `mem_data_out` valid for current `mem_raddr`.
- `mem_waddr`  in  `addr_width`  cpu write address.
- `mem_data_in`  in  8  cpu write data.
- `mem_write`  in  1  cpu write strobe, one byte per cycle.
- `host_addr`  in  `addr_width`  host address.
- `host_wdata`  in  8  host write data.
- `host_we`  in  1  host write request.
- `host_re`  in  1  host read request.
- `host_rdata`  out  8  host read data.
- `host_rvalid`  out  1  one-cycle pulse, `host_rdata` valid.
- `host_busy`  out  1  host request not accepted this cycle; hold it.

Behaviour:
- Reset (`reset`=0, async):
  - Outputs: `mem_ready`=0, `mem_data_out`=0, `host_rvalid`=0, `host_rdata`=0, `host_busy`=0.
  - State machine goes to RELOAD; wait counter=0.
  - RAM contents are NOT cleared and survive reset; this is required so a preload persists across a cpu reset.
- Read state machine, states RELOAD, WAIT, READY:
  - RELOAD: `raddr_q`<=`mem_raddr`, `cnt`<=`wait_states`, `mem_ready`<=0, go to WAIT.
  - WAIT:
    - If `mem_raddr` != `raddr_q`, go to RELOAD behaviour this same edge (recapture, restart count).
    - Else if `cnt`!=0, `cnt`<=`cnt`-1.
    - Else `mem_data_out`<=`rd(raddr_q)`, `mem_ready`<=1, go to READY.
  - READY:
    - If `mem_raddr` != `raddr_q`: `mem_ready`<=0, recapture, go to WAIT (same as RELOAD).
    - Else hold `mem_ready`=1.
    - If the write port hits `raddr_q` this edge, `mem_data_out`<=`mem_data_in` (coherent).
- Read latency: address stable from edge N (the capture edge). `mem_ready` and data are valid after edge N+1+`wait_states`. With `wait_states`=0 this is 1 cycle.
- Read forwarding, `rd(a)`: if `mem_write`=1 and `mem_waddr`==`a` on the sampling edge, return `mem_data_in`; otherwise return the array value.
- cpu write: if `mem_write`=1, `mem[mem_waddr]`<=`mem_data_in` on that edge. No stall, no ready; writes are always accepted regardless of read state.
- Host port:
  - Lower priority than the cpu write port.
  - `host_busy`=1 combinationally when (`host_we`|`host_re`) and `mem_write`=1; the request is not executed and the host holds it.
  - Otherwise:
    - `host_we`: `mem[host_addr]`<=`host_wdata`.
    - `host_re`: `host_rdata`<=`mem[host_addr]`, `host_rvalid`<=1 next cycle.
    - `host_we`&`host_re` together: write executes, read returns the old value.
  - A host write to `raddr_q` while in READY updates `mem_data_out` on the same edge.
- Simultaneous cpu write and host write to the same address: the cpu write is executed and the host sees busy.
- Reset mid-read: `mem_ready` drops immediately (async). Operation resumes via RELOAD after reset deasserts; the counter restarts.
- Address wrap: none needed; addresses are exactly `addr_width` bits, so all values are in range.

Decomposition:
- Package `robin_mem_pkg`:
  - read-state enum (RELOAD, WAIT, READY);
  - `ADDR_WIDTH_DEFAULT`=9;
  - dump address constants `DUMP_BASE`=2, `DUMP_LEN`=4.
- One natural sub-module `ram_byte_2p`: plain 8-bit array with one write port (muxed cpu/host) and two asynchronous read taps (cpu, host). It has no reset. `mem_responder` holds all control, forwarding and arbitration.

Test Plan:
- Preload `mem[0]`=0x12, `mem[1]`=0x34 via host, `wait_states`=1; cpu `raddr`=0 at edge N → `mem_ready`=1, data 0x12 after edge N+2; `raddr`=1 → ready drops next edge, 0x34 two edges later.
- `wait_states`=0, change `raddr` every cycle 0,1,0,1 → `mem_ready` never asserts. Hold at 1 → ready after 1 edge with 0x34.
- cpu writes 0xAB to addr 3 while `raddr`=3 READY → `mem_data_out`=0xAB on the write edge, ready stays 1. Write during WAIT at the final sampling edge → forwarded 0xAB.
- Host write 0x55 to addr 4 same cycle as cpu `mem_write` to addr 7 → `host_busy`=1, addr 4 unchanged; next cycle accepted, host read of addr 4 returns 0x55 with `host_rvalid` one cycle later.
- Write bytes 0x00,0x00,0x01,0x2C to addrs 2..5 via cpu, pulse `reset` low mid-WAIT → `mem_ready`=0 immediately. After release, host reads 2..5 return 0x00,0x00,0x01,0x2C (RAM survives reset).
- Simultaneous `host_we`&`host_re` to addr 9 (old 0x11, new 0x22) → `host_rdata`=0x11; subsequent read returns 0x22.
